// File: rtl/mips_br_pkg.sv
// Shared branch-unit types: branch op codes, resolve-controller states, redirect payload.
package mips_br_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IMM_W = 16;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10
  } br_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_OP = 2'b01,
    REDIR   = 2'b10
  } br_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
  } redirect_t;

endpackage

// File: rtl/br_target_adder.sv
// Branch target: PC+4 plus the sign-extended word offset (imm16 << 2), wrapping mod 2^32.
module br_target_adder
  import mips_br_pkg::*;
(
  input  logic [XLEN-1:0]  pc4_i,
  input  logic [IMM_W-1:0] imm16_i,
  output logic [XLEN-1:0]  target_o
);

  logic [XLEN-1:0] offset;

  assign offset   = {{(XLEN-IMM_W-2){imm16_i[IMM_W-1]}}, imm16_i, 2'b00};
  assign target_o = pc4_i + offset;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// D-stage BEQ/BNE resolve controller: waits for operands, decides, and holds a
// registered IF redirect until accepted, with saturating performance counters.
module branch_resolve_ctrl
  import mips_br_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             d_valid_i,
  input  logic [1:0]       d_op_i,
  input  logic [XLEN-1:0]  d_pc4_i,
  input  logic [IMM_W-1:0] d_imm16_i,
  input  logic [XLEN-1:0]  rs_data_i,
  input  logic             rs_rdy_i,
  input  logic [XLEN-1:0]  rt_data_i,
  input  logic             rt_rdy_i,
  output logic [XLEN-1:0]  cmp_a_o,
  output logic [XLEN-1:0]  cmp_b_o,
  input  logic             cmp_zero_i,
  output logic             d_stall_o,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  input  logic             redirect_ready_i,
  output logic [CNT_W-1:0] br_taken_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  br_state_e        state_q, state_d;
  redirect_t        redir_q, redir_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic            is_beq, is_bne, br, rdy, taken, resolve, d_stall;
  logic [XLEN-1:0] target;

  br_target_adder u_target (
    .pc4_i   (d_pc4_i),
    .imm16_i (d_imm16_i),
    .target_o(target)
  );

  assign cmp_a_o = rs_data_i;
  assign cmp_b_o = rt_data_i;

  assign is_beq = (d_op_i == BR_BEQ);
  assign is_bne = (d_op_i == BR_BNE);
  assign br     = d_valid_i & (is_beq | is_bne);
  assign rdy    = rs_rdy_i & rt_rdy_i;
  // Gated by br so a reserved/none op can never look taken.
  assign taken  = br & ((is_beq & cmp_zero_i) | (is_bne & ~cmp_zero_i));

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      redir_q     <= '0;
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      redir_q     <= redir_d;
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    redir_d     = redir_q;
    taken_cnt_d = taken_cnt_q;
    stall_cnt_d = stall_cnt_q;
    d_stall     = 1'b0;
    resolve     = 1'b0;

    case (state_q)
      IDLE: begin
        if (br) begin
          if (rdy) begin
            resolve = 1'b1;
          end else begin
            d_stall = 1'b1;
            state_d = WAIT_OP;
          end
        end
      end
      WAIT_OP: begin
        stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        if (rdy) begin
          resolve = 1'b1;
          state_d = IDLE;
        end else begin
          d_stall = 1'b1;
        end
      end
      REDIR: begin
        d_stall = 1'b1;
        if (redirect_ready_i) begin
          redir_d.valid = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Taken resolve arms the redirect; it becomes visible to IF next cycle.
    if (resolve && taken) begin
      state_d       = REDIR;
      redir_d.valid = 1'b1;
      redir_d.pc    = target;
      taken_cnt_d   = (taken_cnt_q == CNT_MAX) ? taken_cnt_q : taken_cnt_q + CNT_W'(1);
    end
  end

  assign d_stall_o        = d_stall;
  assign redirect_valid_o = redir_q.valid;
  assign redirect_pc_o    = redir_q.pc;
  assign br_taken_cnt_o   = taken_cnt_q;
  assign stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed vector table, corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_branch_resolve_ctrl;

  localparam int unsigned CNT_W = 3;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset_n;
  logic             d_valid;
  logic [1:0]       d_op;
  logic [31:0]      d_pc4;
  logic [15:0]      d_imm16;
  logic [31:0]      rs_data, rt_data;
  logic             rs_rdy, rt_rdy;
  logic [31:0]      cmp_a, cmp_b;
  logic             cmp_zero;
  logic             d_stall;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ready;
  logic [CNT_W-1:0] br_taken_cnt, stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // External equality comparator, driven from the bench's own operands.
  assign cmp_zero = (rs_data == rt_data);

  branch_resolve_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i           (clk),
    .reset_i         (reset_n),
    .d_valid_i       (d_valid),
    .d_op_i          (d_op),
    .d_pc4_i         (d_pc4),
    .d_imm16_i       (d_imm16),
    .rs_data_i       (rs_data),
    .rs_rdy_i        (rs_rdy),
    .rt_data_i       (rt_data),
    .rt_rdy_i        (rt_rdy),
    .cmp_a_o         (cmp_a),
    .cmp_b_o         (cmp_b),
    .cmp_zero_i      (cmp_zero),
    .d_stall_o       (d_stall),
    .redirect_valid_o(redirect_valid),
    .redirect_pc_o   (redirect_pc),
    .redirect_ready_i(redirect_ready),
    .br_taken_cnt_o  (br_taken_cnt),
    .stall_cnt_o     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a pending redirect, a waiting-for-operands flag, and two counters.
  bit          m_pend, m_wait;
  logic [31:0] m_pc;
  int          m_tc, m_sc;

  function automatic bit cur_br();
    return d_valid && (d_op == 2'b01 || d_op == 2'b10);
  endfunction

  task automatic model_clk();
    bit          br, rdy, tk;
    logic [31:0] off;
    br  = cur_br();
    rdy = rs_rdy && rt_rdy;
    tk  = (d_op == 2'b01) ? (rs_data == rt_data) : (rs_data != rt_data);
    off = 32'($signed(d_imm16));
    if (!reset_n) begin
      m_pend = 0; m_wait = 0; m_pc = 32'd0; m_tc = 0; m_sc = 0;
    end else if (m_pend) begin
      if (redirect_ready) m_pend = 0;
    end else begin
      if (m_wait && m_sc < CMAX) m_sc++;
      if (br && rdy) begin
        m_wait = 0;
        if (tk) begin
          m_pend = 1;
          m_pc   = d_pc4 + off * 32'd4;
          if (m_tc < CMAX) m_tc++;
        end
      end else begin
        m_wait = br;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [1:0] op, input logic [31:0] pc4,
                       input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                       input logic rsr, input logic rtr, input logic rrdy);
    d_valid = vld; d_op = op; d_pc4 = pc4; d_imm16 = imm;
    rs_data = rs; rt_data = rt; rs_rdy = rsr; rt_rdy = rtr; redirect_ready = rrdy;
  endtask

  task automatic idle_in(input logic rrdy);
    drive(1'b0, 2'b00, 32'h0, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1, rrdy);
  endtask

  typedef struct {
    string       nm;
    logic        vld;
    logic [1:0]  op;
    logic [31:0] pc4;
    logic [15:0] imm;
    logic [31:0] rs, rt;
    logic        rsr, rtr, rrdy;
    logic        e_stall, e_rv;
    logic [31:0] e_pc;
    int          e_tc, e_sc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(string nm, logic vld, logic [1:0] op, logic [31:0] pc4,
                              logic [15:0] imm, logic [31:0] rs, logic [31:0] rt,
                              logic rsr, logic rtr, logic rrdy, logic e_stall, logic e_rv,
                              logic [31:0] e_pc, int e_tc, int e_sc);
    vec_t v;
    v.nm = nm; v.vld = vld; v.op = op; v.pc4 = pc4; v.imm = imm; v.rs = rs; v.rt = rt;
    v.rsr = rsr; v.rtr = rtr; v.rrdy = rrdy; v.e_stall = e_stall; v.e_rv = e_rv;
    v.e_pc = e_pc; v.e_tc = e_tc; v.e_sc = e_sc;
    return v;
  endfunction

  initial begin
    // Each row: inputs for one cycle and the outputs expected during that cycle.
    vt.push_back(mk("post_reset", 0, 2'd0, 32'h0,        16'h0,    32'h0,    32'h0,    1, 1, 0, 0, 0, 32'h0,    0, 0));
    vt.push_back(mk("beq_zero",   1, 2'd1, 32'h3004,     16'h0003, 32'h1234, 32'h1234, 1, 1, 1, 0, 0, 32'h0,    0, 0));
    vt.push_back(mk("beq_redir",  0, 2'd0, 32'h0,        16'h0,    32'h0,    32'h0,    1, 1, 1, 1, 1, 32'h3010, 1, 0));
    vt.push_back(mk("bne_equal",  1, 2'd2, 32'h200,      16'h0008, 32'h5,    32'h5,    1, 1, 0, 0, 0, 32'h3010, 1, 0));
    vt.push_back(mk("bne_after",  0, 2'd0, 32'h0,        16'h0,    32'h0,    32'h0,    1, 1, 0, 0, 0, 32'h3010, 1, 0));
    vt.push_back(mk("wait_c1",    1, 2'd1, 32'h3000,     16'hFFFF, 32'h7,    32'h7,    1, 0, 0, 1, 0, 32'h3010, 1, 0));
    vt.push_back(mk("wait_c2",    1, 2'd1, 32'h3000,     16'hFFFF, 32'h7,    32'h7,    1, 0, 0, 1, 0, 32'h3010, 1, 0));
    vt.push_back(mk("wait_c3",    1, 2'd1, 32'h3000,     16'hFFFF, 32'h7,    32'h7,    1, 0, 0, 1, 0, 32'h3010, 1, 1));
    vt.push_back(mk("wait_res",   1, 2'd1, 32'h3000,     16'hFFFF, 32'h7,    32'h7,    1, 1, 0, 0, 0, 32'h3010, 1, 2));
    vt.push_back(mk("wait_redir", 0, 2'd0, 32'h0,        16'h0,    32'h0,    32'h0,    1, 1, 1, 1, 1, 32'h2FFC, 2, 3));
    vt.push_back(mk("bne_taken",  1, 2'd2, 32'h100,      16'h0010, 32'h1,    32'h2,    1, 1, 0, 0, 0, 32'h2FFC, 2, 3));
    for (int i = 0; i < 4; i++)
      vt.push_back(mk("hold_redir", 1, 2'd0, 32'h104,    16'h0,    32'h0,    32'h0,    1, 1, 0, 1, 1, 32'h140,  3, 3));
    vt.push_back(mk("accept",     1, 2'd0, 32'h104,      16'h0,    32'h0,    32'h0,    1, 1, 1, 1, 1, 32'h140,  3, 3));
    vt.push_back(mk("after_acc",  0, 2'd0, 32'h0,        16'h0,    32'h0,    32'h0,    1, 1, 0, 0, 0, 32'h140,  3, 3));
    vt.push_back(mk("op_resvd",   1, 2'd3, 32'h400,      16'h0004, 32'h9,    32'h9,    1, 0, 0, 0, 0, 32'h140,  3, 3));
    vt.push_back(mk("invalid",    0, 2'd1, 32'h400,      16'h0004, 32'h9,    32'h9,    0, 0, 0, 0, 0, 32'h140,  3, 3));
    vt.push_back(mk("wrap",       1, 2'd1, 32'hFFFFFFFC, 16'h0001, 32'hA,    32'hA,    1, 1, 0, 0, 0, 32'h140,  3, 3));
    vt.push_back(mk("wrap_redir", 0, 2'd0, 32'h0,        16'h0,    32'h0,    32'h0,    1, 1, 1, 1, 1, 32'h0,    4, 3));
    vt.push_back(mk("wrap_after", 0, 2'd0, 32'h0,        16'h0,    32'h0,    32'h0,    1, 1, 0, 0, 0, 32'h0,    4, 3));

    reset_n = 1'b0;
    idle_in(1'b0);
    tick();
    tick();
    reset_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].vld, vt[i].op, vt[i].pc4, vt[i].imm, vt[i].rs, vt[i].rt,
            vt[i].rsr, vt[i].rtr, vt[i].rrdy);
      @(negedge clk);
      chk({vt[i].nm, ".d_stall"}, 32'(d_stall), 32'(vt[i].e_stall));
      chk({vt[i].nm, ".rvalid"},  32'(redirect_valid), 32'(vt[i].e_rv));
      chk({vt[i].nm, ".rpc"},     redirect_pc, vt[i].e_pc);
      chk({vt[i].nm, ".taken"},   32'(br_taken_cnt), 32'(vt[i].e_tc));
      chk({vt[i].nm, ".stalls"},  32'(stall_cnt), 32'(vt[i].e_sc));
      chk({vt[i].nm, ".cmp_a"},   cmp_a, vt[i].rs);
      tick();
    end

    // Reset while waiting for operands: must land in IDLE with cleared counters.
    drive(1'b1, 2'd1, 32'h3000, 16'h0004, 32'h3, 32'h3, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_wait.d_stall", 32'(d_stall), 32'd0);
    chk("rst_wait.rvalid",  32'(redirect_valid), 32'd0);
    chk("rst_wait.taken",   32'(br_taken_cnt), 32'd0);
    chk("rst_wait.stalls",  32'(stall_cnt), 32'd0);
    tick();

    // Reset while a redirect is pending: redirect discarded.
    drive(1'b1, 2'd1, 32'h5000, 16'h0010, 32'h8, 32'h8, 1'b1, 1'b1, 1'b0);
    tick();
    idle_in(1'b0);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_redir.rvalid",  32'(redirect_valid), 32'd0);
    chk("rst_redir.rpc",     redirect_pc, 32'h0);
    chk("rst_redir.d_stall", 32'(d_stall), 32'd0);
    tick();

    // Taken-branch counter saturation.
    for (int k = 0; k < CMAX + 2; k++) begin
      drive(1'b1, 2'd2, 32'h800, 16'h0002, 32'(k), 32'(k + 1), 1'b1, 1'b1, 1'b1);
      tick();
      idle_in(1'b1);
      tick();
    end
    @(negedge clk);
    chk("sat.taken", 32'(br_taken_cnt), 32'(CMAX));

    // Stall counter saturation.
    drive(1'b1, 2'd1, 32'h900, 16'h0001, 32'h1, 32'h1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < CMAX + 4; k++) tick();
    @(negedge clk);
    chk("sat.d_stall", 32'(d_stall), 32'd1);
    chk("sat.stalls",  32'(stall_cnt), 32'(CMAX));
    rs_rdy = 1'b1;
    tick();

    // Randomized traffic against the model.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      reset_n = ($urandom_range(0, 63) != 0);
      if (!m_wait) begin
        d_valid = ($urandom_range(0, 3) != 0);
        d_op    = 2'($urandom_range(0, 3));
        d_pc4   = $urandom();
        d_imm16 = 16'($urandom());
      end
      rs_data        = 32'($urandom_range(0, 2));
      rt_data        = 32'($urandom_range(0, 2));
      rs_rdy         = ($urandom_range(0, 3) != 0);
      rt_rdy         = ($urandom_range(0, 3) != 0);
      redirect_ready = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      chk("rnd.d_stall", 32'(d_stall), 32'(m_pend || (cur_br() && !(rs_rdy && rt_rdy))));
      chk("rnd.rvalid",  32'(redirect_valid), 32'(m_pend));
      if (m_pend) chk("rnd.rpc", redirect_pc, m_pc);
      chk("rnd.taken",   32'(br_taken_cnt), 32'(m_tc));
      chk("rnd.stalls",  32'(stall_cnt), 32'(m_sc));
      chk("rnd.cmp_b",   cmp_b, rt_data);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
